cla_nibble_seq_adder: RTL and testbench



---
 rtl/cla_nibble_seq_adder.sv | 142 ++++++++++++++
 tb/tb_cla_nibble_seq_adder.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/cla_nibble_seq_adder.sv
// Area-lean WIDTH-bit adder: one 4-bit CLA reused LSB-first over WIDTH/4 cycles, done N cycles after accept.
// Start is ignored while busy; define CLA_NIBBLE_SEQ_SUB_EN to add the i_sub port (a - b).

module car_look_add (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic       i_cin,
    output logic [3:0] o_sum,
    output logic       o_cout
);
    logic [3:0] w_g;
    logic [3:0] w_p;
    logic [4:0] w_c;

    assign w_g = i_a & i_b;
    assign w_p = i_a ^ i_b;

    // Every carry is expanded directly from g/p and cin, with no ripple between bits.
    assign w_c[0] = i_cin;
    assign w_c[1] = w_g[0] | (w_p[0] & i_cin);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & i_cin);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & i_cin);
    assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                  | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                  | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & i_cin);

    assign o_sum  = w_p ^ w_c[3:0];
    assign o_cout = w_c[4];
endmodule

module cla_nibble_seq_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
`ifdef CLA_NIBBLE_SEQ_SUB_EN
    input  logic             i_sub,
`endif
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout
);
    localparam int N  = WIDTH / 4;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] LAST = IW'(N - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_op_a;
    logic [WIDTH-1:0] r_op_b;
    logic             r_carry;
    logic [IW-1:0]    r_idx;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;

    logic             w_accept;
    logic [WIDTH-1:0] w_b_in;
    logic             w_cin_in;
    logic [3:0]       w_nib_sum;
    logic             w_nib_cout;

    assign w_accept = i_start && (r_state != S_RUN);

`ifdef CLA_NIBBLE_SEQ_SUB_EN
    // Subtract as a + ~b + 1; cout then reads as "no borrow".
    assign w_b_in   = i_sub ? ~i_b  : i_b;
    assign w_cin_in = i_sub ? 1'b1  : i_cin;
`else
    assign w_b_in   = i_b;
    assign w_cin_in = i_cin;
`endif

    car_look_add u_cla (
        .i_a    (r_op_a[{r_idx, 2'b00} +: 4]),
        .i_b    (r_op_b[{r_idx, 2'b00} +: 4]),
        .i_cin  (r_carry),
        .o_sum  (w_nib_sum),
        .o_cout (w_nib_cout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        o_busy = 1'b0;
        o_done = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) w_next = S_RUN;
            end
            S_RUN: begin
                o_busy = 1'b1;
                if (r_idx == LAST) w_next = S_DONE;
            end
            S_DONE: begin
                o_done = 1'b1;
                w_next = i_start ? S_RUN : S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op_a  <= '0;
            r_op_b  <= '0;
            r_carry <= 1'b0;
            r_idx   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
        end else if (w_accept) begin
            r_op_a  <= i_a;
            r_op_b  <= w_b_in;
            r_carry <= w_cin_in;
            r_idx   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
        end else if (r_state == S_RUN) begin
            r_sum[{r_idx, 2'b00} +: 4] <= w_nib_sum;
            r_carry                    <= w_nib_cout;
            r_idx                      <= r_idx + 1'b1;
            if (r_idx == LAST) r_cout <= w_nib_cout;
        end
    end

    assign o_sum  = r_sum;
    assign o_cout = r_cout;
endmodule

// File: tb/tb_cla_nibble_seq_adder.sv
// Directed bench for cla_nibble_seq_adder (WIDTH=16) with a queue-based result scoreboard.
module tb_cla_nibble_seq_adder;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    logic [W:0]   exp_q[$];
    logic [W:0]   mon_exp;
    int           n_checks = 0;
    int           n_fail   = 0;
    int           n_done   = 0;
    int           d0;

    always #5 clk = ~clk;

    cla_nibble_seq_adder #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .i_start (start),
        .i_a     (a),
        .i_b     (b),
        .i_cin   (cin),
`ifdef CLA_NIBBLE_SEQ_SUB_EN
        .i_sub   (sub),
`endif
        .o_busy  (busy),
        .o_done  (done),
        .o_sum   (sum),
        .o_cout  (cout)
    );

    task automatic check(input string name, input logic [W:0] act, input logic [W:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            n_done++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: got sum=0x%0h cout=%0b, expected no result", sum, cout);
            end else begin
                mon_exp = exp_q.pop_front();
                check("result", {cout, sum}, mon_exp);
            end
        end
    end

    // Leaves the caller 1 time unit after the accepting edge E0.
    task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc, input logic ts);
        @(posedge clk);
        #1;
        a = ta; b = tb; cin = tc; sub = ts; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc,
                          input logic ts, input logic [W-1:0] es, input logic ec);
        exp_q.push_back({ec, es});
        issue(ta, tb, tc, ts);
        for (int k = 0; k < 4; k++) begin
            check("busy_in_run", {16'h0, busy}, 17'h1);
            check("done_in_run", {16'h0, done}, 17'h0);
            @(posedge clk);
            #1;
        end
        check("done_after_4", {16'h0, done}, 17'h1);
        check("busy_in_done", {16'h0, busy}, 17'h0);
        @(posedge clk);
        #1;
        check("done_one_cycle", {16'h0, done}, 17'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", {16'h0, busy}, 17'h0);
        check("rst_done", {16'h0, done}, 17'h0);
        check("rst_sum_cout", {cout, sum}, 17'h0);
        rst = 1'b0;

        run_op(16'h1234, 16'h0FFF, 1'b0, 1'b0, 16'h2233, 1'b0);
        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1);
        run_op(16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1);
        run_op(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1);
        run_op(16'h8421, 16'h1248, 1'b0, 1'b0, 16'h9669, 1'b0);
        run_op(16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0);

        // Start while busy must be ignored.
        exp_q.push_back({1'b0, 16'h2233});
        d0 = n_done;
        issue(16'h1234, 16'h0FFF, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        a = '0; b = '0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("busy_after_ignored_start", {16'h0, busy}, 17'h1);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        check("done_ignored_case", {16'h0, done}, 17'h1);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        check("single_done_pulse", 17'(n_done - d0), 17'd1);

        // Start held high: back-to-back results every 5 cycles.
        repeat (3) exp_q.push_back({1'b0, 16'h0002});
        @(posedge clk);
        #1;
        a = 16'h0001; b = 16'h0001; cin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            repeat (4) begin
                @(posedge clk);
                #1;
            end
            check("b2b_done", {16'h0, done}, 17'h1);
            if (i == 2) start = 1'b0;
            @(posedge clk);
            #1;
            check("b2b_done_low", {16'h0, done}, 17'h0);
            check("b2b_busy", {16'h0, busy}, (i == 2) ? 17'h0 : 17'h1);
        end

        // Reset mid-RUN discards the operation.
        issue(16'h1234, 16'h0FFF, 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midrst_busy", {16'h0, busy}, 17'h0);
        check("midrst_done", {16'h0, done}, 17'h0);
        check("midrst_sum_cout", {cout, sum}, 17'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        d0 = n_done;
        repeat (8) @(posedge clk);
        #1;
        check("no_done_after_rst", 17'(n_done - d0), 17'd0);
        run_op(16'h1234, 16'h0FFF, 1'b0, 1'b0, 16'h2233, 1'b0);

`ifdef CLA_NIBBLE_SEQ_SUB_EN
        run_op(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0);
        run_op(16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1);
        run_op(16'h0007, 16'h0005, 1'b1, 1'b0, 16'h000D, 1'b0);
`endif

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
        #1;
        check("queue_drained", 17'(exp_q.size()), 17'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
